// File: rtl/fractal_sync_tx.sv
// Fractal-sync link transmitter: pops requests from a local queue and sends each one as a
// single-cycle sync pulse, limited by far-end credits and a minimum gap between pulses.
package fractal_sync_pkg;
  typedef struct packed {
    logic [1:0] aggr;
    logic [3:0] id;
  } fsync_sig_t;

  typedef struct packed {
    logic       sync;
    fsync_sig_t sig;
    logic [1:0] src;
  } fsync_req_t;
endpackage

module fractal_sync_tx #(
  parameter type          fsync_req_t = fractal_sync_pkg::fsync_req_t,
  parameter int unsigned  CREDITS     = 1,
  parameter int unsigned  MIN_GAP     = 0,
  localparam int unsigned CNT_W       = $clog2(CREDITS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             empty_i,
  input  fsync_req_t       req_i,
  output logic             pop_o,
  output fsync_req_t       req_o,
  input  logic             credit_i,
  output logic [CNT_W-1:0] credits_o,
  output logic             busy_o,
  output logic             error_invalid_o,
  output logic             error_credit_o
);
  localparam int unsigned      GAP_W = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CREDITS);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t           state_q, state_d;
  fsync_req_t       req_q, req_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_inv_q, err_cred_q, err_cred_d;
  logic             launch_window, head_invalid, launch, drop;

  // Queue handshake: the head is offered whenever !empty_i; pop_o in the same cycle is the
  // only transfer event. Nothing is popped while reset is asserted.
  always_comb begin
    launch_window = !rst_i && ((state_q == IDLE) || ((state_q == SEND) && (MIN_GAP == 0)));
    head_invalid  = (req_i.sig.aggr == '0);
    launch        = launch_window && !empty_i && !head_invalid && (credits_q != '0);
    drop          = launch_window && !empty_i && head_invalid;
    pop_o         = launch || drop;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: if (launch) state_d = SEND;
      SEND: begin
        // The IDLE launch cycle is itself one gap cycle, so GAP covers the other MIN_GAP-1.
        if (MIN_GAP > 1) begin
          state_d = GAP;
          gap_d   = GAP_W'(MIN_GAP - 1);
        end else if (launch) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    req_d.sync = 1'b0;
    if (launch) begin
      req_d      = req_i;
      req_d.sync = 1'b1;
    end
    credits_d  = credits_q;
    err_cred_d = 1'b0;
    if (launch && !credit_i) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!launch && credit_i) begin
      if (credits_q == FULL) err_cred_d = 1'b1;
      else                   credits_d  = credits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      credits_q  <= FULL;
      gap_q      <= '0;
      err_inv_q  <= 1'b0;
      err_cred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      credits_q  <= credits_d;
      gap_q      <= gap_d;
      err_inv_q  <= drop;
      err_cred_q <= err_cred_d;
    end
  end

  assign req_o           = req_q;
  assign credits_o       = credits_q;
  assign busy_o          = (state_q != IDLE);
  assign error_invalid_o = err_inv_q;
  assign error_credit_o  = err_cred_q;
endmodule
